id_stage: RTL

- IF/ID pipeline stage of the RISC-V core.
- Registers each fetched instruction and classifies it into the 6-bit control-ROM index consumed by the control unit.
- Extracts register fields, detects load-use hazards against EX, and stalls fetch or inserts bubbles.
- Handles branch/jump redirect flushes; keeps a saturating stall counter and a sticky illegal-instruction flag.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/inst_classifier.sv | 70 +++++++
 rtl/id_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, control-ROM index and NOP constants for the core
//
// Purpose: single source of truth for the RV32 opcodes the decoder recognises,
// the 6-bit control-ROM indices the control unit consumes, and the canonical
// NOP instruction word (addi x0, x0, 0).
// Ports: none (package).
package core_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // funct3 values of the two supported CSR instructions
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    // Control-ROM indices
    localparam logic [5:0] IDX_R       = 6'd0;
    localparam logic [5:0] IDX_IMM     = 6'd1;
    localparam logic [5:0] IDX_LOAD    = 6'd2;
    localparam logic [5:0] IDX_STORE   = 6'd3;
    localparam logic [5:0] IDX_BRANCH  = 6'd4;
    localparam logic [5:0] IDX_JAL     = 6'd5;
    localparam logic [5:0] IDX_JALR    = 6'd6;
    localparam logic [5:0] IDX_LUI     = 6'd7;
    localparam logic [5:0] IDX_AUIPC   = 6'd8;
    localparam logic [5:0] IDX_CSRRW   = 6'd9;
    localparam logic [5:0] IDX_CSRRWI  = 6'd10;
    // NOP_IDX selects a ROM row with no register or memory writes
    localparam logic [5:0] NOP_IDX     = 6'd11;
    localparam logic [5:0] ILLEGAL_IDX = 6'd63;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_classifier.sv
// rtl/inst_classifier.sv - combinational instruction to control-ROM index classifier
//
// Purpose: map a 32-bit instruction to its control-ROM index and report which
// register source fields it actually reads (used for load-use detection).
// Ports:
//   i_inst      in  32  instruction word
//   o_rom_idx   out 6   control-ROM index (ILLEGAL_IDX when unrecognised)
//   o_uses_rs1  out 1   instruction reads rs1
//   o_uses_rs2  out 1   instruction reads rs2
module inst_classifier
    import core_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [5:0]  o_rom_idx,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [5:0] w_idx;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];

    always_comb begin
        w_idx = ILLEGAL_IDX;
        unique case (w_opcode)
            OP_R:      w_idx = IDX_R;
            OP_IMM:    w_idx = IDX_IMM;
            OP_LOAD:   w_idx = IDX_LOAD;
            OP_STORE:  w_idx = IDX_STORE;
            OP_BRANCH: w_idx = IDX_BRANCH;
            OP_JAL:    w_idx = IDX_JAL;
            OP_JALR:   w_idx = IDX_JALR;
            OP_LUI:    w_idx = IDX_LUI;
            OP_AUIPC:  w_idx = IDX_AUIPC;
            OP_SYSTEM: begin
                if (w_funct3 == F3_CSRRW) begin
                    w_idx = IDX_CSRRW;
                end else if (w_funct3 == F3_CSRRWI) begin
                    w_idx = IDX_CSRRWI;
                end
            end
            default:   w_idx = ILLEGAL_IDX;
        endcase
    end

    // Source usage is derived from the index, so illegal words never stall.
    always_comb begin
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        case (w_idx)
            IDX_R, IDX_STORE, IDX_BRANCH: begin
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
            end
            IDX_IMM, IDX_LOAD, IDX_JALR, IDX_CSRRW: begin
                o_uses_rs1 = 1'b1;
            end
            default: begin
                o_uses_rs1 = 1'b0;
                o_uses_rs2 = 1'b0;
            end
        endcase
    end

    assign o_rom_idx = w_idx;

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - IF/ID pipeline register with classification and load-use stall
//
// Purpose: register each fetched instruction, present its control-ROM index and
// register fields to the control unit, stall fetch on a load-use hazard against
// EX, flush on redirect, count stall cycles and flag illegal instructions.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_valid, if_inst, if_pc        fetch request
//   if_ready                        stage accepts fetch (~hazard)
//   ex_valid, ex_is_load, ex_rd     EX-stage state for hazard detection
//   redirect                        taken branch/jump in EX, flush ID
//   id_valid, id_rom_idx            decoded instruction handshake/index
//   id_inst, id_pc                  registered instruction and PC
//   id_rs1, id_rs2, id_rd, id_funct3  fields of id_inst
//   stall_cnt                       saturating count of hazard cycles
//   illegal                         sticky illegal-instruction flag
module id_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             redirect,
    output logic             id_valid,
    output logic [5:0]       id_rom_idx,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [4:0]       id_rd,
    output logic [2:0]       id_funct3,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             illegal
);

    logic             r_valid;
    logic [31:0]      r_inst;
    logic [31:0]      r_pc;
    logic [5:0]       r_rom_idx;
    logic             r_uses_rs1;
    logic             r_uses_rs2;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_illegal;

    logic [5:0]       w_if_idx;
    logic             w_if_uses_rs1;
    logic             w_if_uses_rs2;
    logic             w_hazard;

    inst_classifier u_classifier (
        .i_inst     (if_inst),
        .o_rom_idx  (w_if_idx),
        .o_uses_rs1 (w_if_uses_rs1),
        .o_uses_rs2 (w_if_uses_rs2)
    );

    // A load in EX whose destination is read by the instruction held in ID.
    // x0 never creates a dependency.
    assign w_hazard = r_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((r_uses_rs1 & (r_inst[19:15] == ex_rd)) |
                       (r_uses_rs2 & (r_inst[24:20] == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_inst      <= NOP_INST;
            r_pc        <= RESET_PC;
            r_rom_idx   <= NOP_IDX;
            r_uses_rs1  <= 1'b0;
            r_uses_rs2  <= 1'b0;
            r_stall_cnt <= '0;
            r_illegal   <= 1'b0;
        end else if (redirect) begin
            // Flush wins over a stall; the word fetched this cycle is dropped.
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_rom_idx  <= NOP_IDX;
            r_uses_rs1 <= 1'b0;
            r_uses_rs2 <= 1'b0;
        end else if (w_hazard) begin
            if (r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else if (if_valid) begin
            r_valid    <= 1'b1;
            r_inst     <= if_inst;
            r_pc       <= if_pc;
            r_rom_idx  <= w_if_idx;
            r_uses_rs1 <= w_if_uses_rs1;
            r_uses_rs2 <= w_if_uses_rs2;
            if (w_if_idx == ILLEGAL_IDX) begin
                r_illegal <= 1'b1;
            end
        end else begin
            r_valid   <= 1'b0;
            r_rom_idx <= NOP_IDX;
        end
    end

    // During a stall the held instruction is hidden behind a bubble.
    assign if_ready   = ~w_hazard;
    assign id_valid   = r_valid & ~w_hazard;
    assign id_rom_idx = w_hazard ? NOP_IDX : r_rom_idx;
    assign id_inst    = r_inst;
    assign id_pc      = r_pc;
    assign id_rs1     = r_inst[19:15];
    assign id_rs2     = r_inst[24:20];
    assign id_rd      = r_inst[11:7];
    assign id_funct3  = r_inst[14:12];
    assign stall_cnt  = r_stall_cnt;
    assign illegal    = r_illegal;

endmodule
